// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared types for the GCN aggregation path
package gcn_pkg;

  // Default channel geometry of the aggregation path
  localparam int GCN_WEIGHT_COLS    = 3;
  localparam int GCN_DOT_PROD_WIDTH = 16;

  // One dot-product row: WEIGHT_COLS elements of DOT_PROD_WIDTH bits, element c at [c]
  typedef logic [GCN_WEIGHT_COLS-1:0][GCN_DOT_PROD_WIDTH-1:0] row_t;

  // Accumulator pass sequencing
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_add_row.sv
// rtl/sat_add_row.sv - element-wise row adder with wrap or saturate on carry
module sat_add_row #(
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter bit SATURATE       = 1'b0
) (
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] a,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] b,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] sum,
  output logic                                       overflow
);

  logic [WEIGHT_COLS-1:0] carry;

  // Add each element one bit wider; the extra bit is the carry that drives wrap/clamp
  always_comb begin
    carry = '0;
    sum   = '0;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      logic [DOT_PROD_WIDTH:0] wide;
      wide     = {1'b0, a[c]} + {1'b0, b[c]};
      carry[c] = wide[DOT_PROD_WIDTH];
      if (SATURATE && wide[DOT_PROD_WIDTH]) begin
        sum[c] = '1;
      end else begin
        sum[c] = wide[DOT_PROD_WIDTH-1:0];
      end
    end
  end

  assign overflow = |carry;

endmodule

// File: rtl/row_accumulator.sv
// rtl/row_accumulator.sv - accumulates tagged rows into a buffer and drains it per pass
module row_accumulator
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = GCN_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH = GCN_DOT_PROD_WIDTH,
  parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
  parameter bit SATURATE       = 1'b0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [FEATURE_WIDTH-1:0]                   in_row_addr,
  input  logic                                       in_last,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [FEATURE_WIDTH-1:0]                   out_row_addr,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] out_data,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       overflow,
  output logic                                       addr_err
);

  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_vec_t;

  localparam logic [FEATURE_WIDTH-1:0] LAST_ROW   = FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [FEATURE_WIDTH:0]   ROWS_BOUND = (FEATURE_WIDTH + 1)'(FEATURE_ROWS);

  state_e                   state_q, state_d;
  logic [FEATURE_WIDTH-1:0] cnt_q, cnt_d;
  logic [FEATURE_ROWS-1:0]  written_q, written_d;
  row_vec_t                 buf_q [FEATURE_ROWS];
  row_vec_t                 buf_d [FEATURE_ROWS];
  logic                     overflow_q, overflow_d;
  logic                     addr_err_q, addr_err_d;

  logic     addr_ok;
  logic     accept;
  row_vec_t cur_row;
  row_vec_t sum_row;
  logic     add_ovf;

  assign addr_ok = ({1'b0, in_row_addr} < ROWS_BOUND);
  assign accept  = in_valid && in_ready;

  // A row not yet written this pass contributes zero, so stale data never leaks in
  assign cur_row = (addr_ok && written_q[in_row_addr]) ? buf_q[in_row_addr] : '0;

  sat_add_row #(
    .WEIGHT_COLS    (WEIGHT_COLS),
    .DOT_PROD_WIDTH (DOT_PROD_WIDTH),
    .SATURATE       (SATURATE)
  ) u_add (
    .a        (cur_row),
    .b        (in_data),
    .sum      (sum_row),
    .overflow (add_ovf)
  );

  // Next-state: pass sequencing, buffer writes, drain counter and sticky flags
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    written_d  = written_q;
    buf_d      = buf_q;
    overflow_d = overflow_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          cnt_d      = '0;
          written_d  = '0;
          overflow_d = 1'b0;
          addr_err_d = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (addr_ok) begin
            buf_d[in_row_addr]     = sum_row;
            written_d[in_row_addr] = 1'b1;
            if (add_ovf) overflow_d = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST_ROW) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset clears everything including buffer contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++) buf_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
      for (int r = 0; r < FEATURE_ROWS; r++) buf_q[r] <= buf_d[r];
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == DRAIN);
  assign out_row_addr = out_valid ? cnt_q : '0;
  assign out_data     = (out_valid && written_q[cnt_q]) ? buf_q[cnt_q] : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign overflow     = overflow_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_row_accumulator.sv
// tb/tb_row_accumulator.sv - self-checking bench for row_accumulator, wrap and saturate builds
module tb_row_accumulator;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int W    = 16;
  localparam int AW   = 3;

  typedef logic [COLS-1:0][W-1:0] row_t;
  typedef struct {
    logic [AW-1:0] addr;
    row_t          wrap;
    row_t          sat;
  } exp_t;

  logic          clk, rst_n, start, in_valid, in_last, out_ready;
  logic [AW-1:0] in_row_addr;
  row_t          in_data;

  logic          w_in_ready, w_out_valid, w_busy, w_done, w_overflow, w_addr_err;
  logic [AW-1:0] w_out_row_addr;
  row_t          w_out_data;
  logic          s_in_ready, s_out_valid, s_busy, s_done, s_overflow, s_addr_err;
  logic [AW-1:0] s_out_row_addr;
  row_t          s_out_data;

  int tests = 0;
  int fails = 0;

  exp_t sb[$];
  row_t mw [ROWS];
  row_t ms [ROWS];
  logic [ROWS-1:0] mwr;
  logic movf_w, movf_s, maerr;

  row_accumulator #(.FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS), .DOT_PROD_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_row_addr(in_row_addr), .in_last(in_last), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_row_addr(w_out_row_addr),
    .out_data(w_out_data), .busy(w_busy), .done(w_done), .overflow(w_overflow), .addr_err(w_addr_err)
  );

  row_accumulator #(.FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS), .DOT_PROD_WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_row_addr(in_row_addr), .in_last(in_last), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_row_addr(s_out_row_addr),
    .out_data(s_out_data), .busy(s_busy), .done(s_done), .overflow(s_overflow), .addr_err(s_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrap"}, {w_in_ready, w_out_valid, w_out_row_addr, w_out_data, w_busy, w_done, w_overflow, w_addr_err}, 64'h0);
    check({tag, "_sat"},  {s_in_ready, s_out_valid, s_out_row_addr, s_out_data, s_busy, s_done, s_overflow, s_addr_err}, 64'h0);
  endtask

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.addr = AW'(r);
      e.wrap = mwr[r] ? mw[r] : '0;
      e.sat  = mwr[r] ? ms[r] : '0;
      sb.push_back(e);
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    mwr = '0; movf_w = 1'b0; movf_s = 1'b0; maerr = 1'b0;
    check("accum_entered", {w_in_ready, s_in_ready, w_busy, s_busy}, 4'b1111);
    check("flags_cleared", {w_overflow, s_overflow, w_addr_err, s_addr_err}, 4'b0000);
  endtask

  task automatic beat(input int addr, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] d2, input logic last);
    row_t d;
    logic [W:0] s;
    d[0] = d0; d[1] = d1; d[2] = d2;
    in_valid = 1'b1; in_row_addr = AW'(addr); in_data = d; in_last = last;
    check("in_ready", {w_in_ready, s_in_ready}, 2'b11);
    if (addr < ROWS) begin
      for (int c = 0; c < COLS; c++) begin
        s = {1'b0, (mwr[addr] ? mw[addr][c] : {W{1'b0}})} + {1'b0, d[c]};
        mw[addr][c] = s[W-1:0];
        if (s[W]) movf_w = 1'b1;
        s = {1'b0, (mwr[addr] ? ms[addr][c] : {W{1'b0}})} + {1'b0, d[c]};
        ms[addr][c] = s[W] ? {W{1'b1}} : s[W-1:0];
        if (s[W]) movf_s = 1'b1;
      end
      mwr[addr] = 1'b1;
    end else begin
      maerr = 1'b1;
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    if (last) push_expected();
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 repeating
  task automatic drain(input int mode);
    int   hs;
    int   cyc;
    logic stalled;
    logic [AW-1:0] held_a;
    row_t held_w, held_s;
    exp_t e;
    hs = 0; cyc = 0; stalled = 1'b0; held_a = '0; held_w = '0; held_s = '0;
    check("first_out_valid", {w_out_valid, s_out_valid, w_in_ready, s_in_ready}, 4'b1100);
    while (hs < ROWS && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (stalled) begin
        check("stall_hold_addr", w_out_row_addr, held_a);
        check("stall_hold_wrap", w_out_data, held_w);
        check("stall_hold_sat", s_out_data, held_s);
      end
      if (w_out_valid) begin
        if (out_ready) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("drain_addr", {w_out_row_addr, s_out_row_addr}, {e.addr, e.addr});
            check("drain_wrap", w_out_data, e.wrap);
            check("drain_sat", s_out_data, e.sat);
          end else begin
            check("sb_underflow", 1'b1, 1'b0);
          end
          hs++;
          stalled = 1'b0;
        end else begin
          held_a = w_out_row_addr; held_w = w_out_data; held_s = s_out_data;
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_handshakes", hs, ROWS);
    check("done_pulse", {w_done, s_done, w_busy, s_busy, w_out_valid, s_out_valid}, 6'b111100);
    check("sticky_flags", {w_overflow, s_overflow, w_addr_err, s_addr_err}, {movf_w, movf_s, maerr, maerr});
    tick();
    check("back_to_idle", {w_done, s_done, w_busy, s_busy}, 4'b0000);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic basic_pass();
    start_pass();
    beat(0, 16'd1, 16'd2, 16'd3, 1'b0);
    beat(0, 16'd4, 16'd5, 16'd6, 1'b0);
    beat(2, 16'd7, 16'd8, 16'd9, 1'b1);
    drain(0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_row_addr = '0; in_data = '0;
    mwr = '0; movf_w = 1'b0; movf_s = 1'b0; maerr = 1'b0;
    for (int r = 0; r < ROWS; r++) begin mw[r] = '0; ms[r] = '0; end
    tick();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick();

    // Basic accumulation with back-to-back beats to the same row
    basic_pass();

    // Wrap vs saturate on the same carry-producing beats
    start_pass();
    beat(1, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    beat(1, 16'd2, 16'd1, 16'd0, 1'b1);
    drain(0);

    // Back-pressure across several rows
    start_pass();
    beat(5, 16'd100, 16'd200, 16'd300, 1'b0);
    beat(3, 16'd11, 16'd22, 16'd33, 1'b0);
    beat(5, 16'd1, 16'd1, 16'd1, 1'b1);
    drain(1);

    // Bad address ending the pass, then stale-data pass writing only r3
    start_pass();
    beat(0, 16'd10, 16'd20, 16'd30, 1'b0);
    beat(7, 16'd1, 16'd1, 16'd1, 1'b1);
    check("addr_err_set", {w_addr_err, s_addr_err}, 2'b11);
    drain(0);
    start_pass();
    beat(3, 16'd42, 16'd43, 16'd44, 1'b1);
    drain(0);

    // Protocol guards: in_valid in IDLE, start in ACCUM, in_valid and start in DRAIN
    in_valid = 1'b1; in_row_addr = '0; in_data = {16'd5, 16'd5, 16'd5};
    tick();
    check("idle_ignores_valid", {w_in_ready, s_in_ready, w_busy, s_busy}, 4'b0000);
    in_valid = 1'b0;
    start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_accum", {w_in_ready, s_in_ready, w_out_valid, s_out_valid}, 4'b1100);
    beat(0, 16'd1, 16'd1, 16'd1, 1'b1);
    in_valid = 1'b1; in_row_addr = '0; in_data = {16'd9, 16'd9, 16'd9};
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_drain", {w_out_valid, s_out_valid, w_out_row_addr, s_out_row_addr}, {2'b11, 3'd0, 3'd0});
    drain(0);
    in_valid = 1'b0;

    // Reset in the middle of a drain, then a fresh basic pass
    start_pass();
    beat(0, 16'd1, 16'd2, 16'd3, 1'b0);
    beat(0, 16'd4, 16'd5, 16'd6, 1'b0);
    beat(2, 16'd7, 16'd8, 16'd9, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      check("pre_reset_drain", {w_out_row_addr, w_out_data}, {e.addr, e.wrap});
      tick();
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    mwr = '0; movf_w = 1'b0; movf_s = 1'b0; maerr = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset_idle");
    basic_pass();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/row_accumulator.md
Name: row_accumulator

Overview:
Sequential, parametrised successor to the combinational row adder in the GCN aggregation path. It accepts a stream of WEIGHT_COLS-wide dot-product rows, each tagged with a destination row address, and accumulates them element-wise into an internal FEATURE_ROWS x WEIGHT_COLS buffer. At end of pass it drains the buffer row by row over a valid/ready output port. Arithmetic is selectable: wrap or saturate.

Parameters:
- FEATURE_ROWS, 6, number of accumulator rows (buffer depth).
- WEIGHT_COLS, 3, elements per row (channel count).
- DOT_PROD_WIDTH, 16, unsigned element width.
- FEATURE_WIDTH, $clog2(FEATURE_ROWS), row address width.
- SATURATE, 0, 0 = modulo-2^DOT_PROD_WIDTH wrap; 1 = clamp at all-ones.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a pass (honoured only in IDLE).
- in_valid  in  1  input beat valid.
- in_ready  out  1  high only in ACCUM.
- in_row_addr  in  FEATURE_WIDTH  destination row.
- in_last  in  1  marks final beat of pass.
- in_data  in  [WEIGHT_COLS][DOT_PROD_WIDTH]  row to add.
- out_valid  out  1  drain row valid.
- out_ready  in  1  downstream accepts.
- out_row_addr  out  FEATURE_WIDTH  index of drained row.
- out_data  out  [WEIGHT_COLS][DOT_PROD_WIDTH]  accumulated row.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at pass end.
- overflow  out  1  sticky; any element carry-out this pass.
- addr_err  out  1  sticky; beat with in_row_addr >= FEATURE_ROWS.

Behaviour:
- Reset (async, any state): state=IDLE, all buffer rows and row-written bits cleared, in_ready=0, out_valid=0, out_row_addr=0, out_data=0, busy=0, done=0, overflow=0, addr_err=0.
- States: IDLE -> ACCUM (start=1) -> DRAIN (in_last beat accepted) -> DONE (final drain handshake) -> IDLE (unconditional, next cycle).
- On IDLE->ACCUM edge: clear all row-written bits, overflow and addr_err. Buffer data is not cleared; unwritten rows read as zero.
- ACCUM: beat accepted when in_valid && in_ready. Same edge: buffer[addr][c] <= (written ? buffer[addr][c] : 0) + in_data[c] for all c; set written[addr]. One beat per cycle; back-to-back beats to the same row must accumulate correctly.
- Width rule: sum computed at DOT_PROD_WIDTH+1 bits. On carry, overflow<=1. SATURATE=0 stores the low DOT_PROD_WIDTH bits. SATURATE=1 stores 2^DOT_PROD_WIDTH-1.
- Out-of-range addr: beat accepted (handshake completes), buffer untouched, addr_err<=1. in_last on such a beat still ends ACCUM.
- DRAIN: counter runs 0..FEATURE_ROWS-1. out_valid=1. out_row_addr=counter. out_data = written ? buffer[counter] : 0. Counter advances only on out_valid && out_ready. Outputs hold stable while stalled. First out_valid arrives the cycle after the in_last handshake.
- DONE: done=1 for exactly one cycle. busy=1. out_valid=0.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored (in_ready=0).
- overflow and addr_err remain readable after the pass until the next start.

Decomposition:
- Package gcn_pkg: state enum (IDLE, ACCUM, DRAIN, DONE) and a row-vector typedef parametrised on WEIGHT_COLS x DOT_PROD_WIDTH, shared with the row adder path.
- One sub-module, sat_add_row: combinational WEIGHT_COLS-wide adder with SATURATE parameter and per-element carry. Outputs are the sum row and overflow (OR of carries).

Test Plan:
- Basic accumulation: start; beats (r0,[1,2,3]), (r0,[4,5,6]), (r2,[7,8,9],last); out_ready=1 -> drain r0=[5,7,9], r1=0, r2=[7,8,9], r3..r5=0; done one cycle after the r5 handshake; overflow=0.
- Wrap vs saturate: r1 gets [0xFFFF,1,0] then [2,1,0]. SATURATE=0 -> [0x0001,2,0], overflow=1. SATURATE=1 -> [0xFFFF,2,0], overflow=1.
- Back-pressure: out_ready toggles 1,0,0,1,... -> each row is held stable while stalled, no row is skipped or duplicated, and exactly 6 handshakes occur.
- Bad address and stale data: beat to addr 7 (FEATURE_ROWS=6) -> addr_err=1 and buffer unchanged. A second pass writing only r3 drains r0..r2 and r4..r5 as 0, not as prior-pass values.
- Reset mid-DRAIN: assert rst_n=0 after 2 handshakes -> all outputs 0 at once. A fresh pass then behaves as the basic test.
- Protocol guards: start pulsed during ACCUM, and in_valid during IDLE/DRAIN -> no state change, no buffer change.
